// File: rtl/layer_pkg.sv
// Shared constants and helpers for the layer compositor: channel ordering,
// per-layer slice offsets into the packed colour bus, and the index width rule.
package layer_pkg;

  localparam int COLOR_W_DEF = 8;
  localparam int MAX_LAYERS  = 16;

  // Channel order inside a packed {R,G,B} pixel, red in the most significant bits.
  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int rgb_lsb(input int layer, input int cw);
    return layer * 3 * cw;
  endfunction

  function automatic int chan_lsb(input chan_e ch, input int cw);
    return (2 - int'(ch)) * cw;
  endfunction

endpackage

// File: rtl/layer_prio_sel.sv
// Combinational priority encoder: highest set bit of eff_i wins, and the
// next-lower set bit is reported as the layer directly beneath the winner.
module layer_prio_sel
  import layer_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int IDX_W      = idx_width(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0] eff_i,
  output logic [IDX_W-1:0]      win_idx_o,
  output logic                  win_vld_o,
  output logic [IDX_W-1:0]      below_idx_o,
  output logic                  below_vld_o
);

  // Ascending scan: each hit demotes the previous winner to "below".
  always_comb begin
    win_idx_o   = '0;
    win_vld_o   = 1'b0;
    below_idx_o = '0;
    below_vld_o = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (eff_i[i]) begin
        below_idx_o = win_idx_o;
        below_vld_o = win_vld_o;
        win_idx_o   = IDX_W'(i);
        win_vld_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// N-layer priority compositor with 2-cycle latency, per-frame shadowed layer mask
// and vs frame counter. Optional averaging with the layer below: LAYER_BLEND_EN.
module layer_compositor
  import layer_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = COLOR_W_DEF,
  parameter int IDX_W      = idx_width(NUM_LAYERS),
  parameter int FCNT_W     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [9:0]                      x_pos,
  input  logic [9:0]                      y_pos,
  input  logic                            de_in,
  input  logic                            hs_in,
  input  logic                            vs_in,
  input  logic [NUM_LAYERS-1:0]           req,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] rgb_in,
  input  logic [NUM_LAYERS-1:0]           layer_en_in,
  input  logic [3*COLOR_W-1:0]            bg_color,
`ifdef LAYER_BLEND_EN
  input  logic [NUM_LAYERS-1:0]           blend_mask,
`endif
  output logic [COLOR_W-1:0]              red,
  output logic [COLOR_W-1:0]              green,
  output logic [COLOR_W-1:0]              blue,
  output logic                            de_out,
  output logic                            hs_out,
  output logic                            vs_out,
  output logic [9:0]                      x_out,
  output logic [9:0]                      y_out,
  output logic [IDX_W-1:0]                top_idx,
  output logic                            hit,
  output logic [FCNT_W-1:0]               frame_cnt
);

  localparam int PIX_W = 3 * COLOR_W;

  logic [NUM_LAYERS-1:0]       req_s1_q;
  logic [NUM_LAYERS*PIX_W-1:0] rgb_s1_q;
  logic                        de_s1_q, hs_s1_q, vs_s1_q;
  logic [9:0]                  x_s1_q, y_s1_q;

  logic                        vs_prev_q;
  logic                        vs_rise;
  logic [NUM_LAYERS-1:0]       mask_q, mask_d;
  logic [FCNT_W-1:0]           fcnt_q, fcnt_d;

  logic [PIX_W-1:0]            pix_q, pix_d;
  logic                        hit_q, hit_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        de_s2_q, hs_s2_q, vs_s2_q;
  logic [9:0]                  x_s2_q, y_s2_q;

  logic [PIX_W-1:0]            layer_rgb [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]       eff;
  logic [IDX_W-1:0]            win_idx, below_idx;
  logic                        win_vld, below_vld;
  logic [PIX_W-1:0]            win_rgb, mix_rgb;

  // The mask is only sampled on a vs rising edge so a frame never changes mid-scan.
  assign vs_rise = vs_in & ~vs_prev_q;

  always_comb begin
    mask_d = mask_q;
    fcnt_d = fcnt_q;
    if (vs_rise) begin
      mask_d = layer_en_in;
      fcnt_d = fcnt_q + FCNT_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_slice
      assign layer_rgb[gi] = rgb_s1_q[rgb_lsb(gi, COLOR_W) +: PIX_W];
    end
  endgenerate

  assign eff = req_s1_q & mask_q;

  layer_prio_sel #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_prio_sel (
    .eff_i       (eff),
    .win_idx_o   (win_idx),
    .win_vld_o   (win_vld),
    .below_idx_o (below_idx),
    .below_vld_o (below_vld)
  );

`ifdef LAYER_BLEND_EN
  logic [PIX_W-1:0]   below_rgb;
  logic [COLOR_W:0]   blend_sum;
`endif

  always_comb begin
    win_rgb = layer_rgb[win_idx];
    mix_rgb = win_rgb;
`ifdef LAYER_BLEND_EN
    below_rgb = below_vld ? layer_rgb[below_idx] : bg_color;
    blend_sum = '0;
    if (blend_mask[win_idx]) begin
      for (int c = 0; c < 3; c++) begin
        blend_sum = {1'b0, win_rgb[c*COLOR_W +: COLOR_W]} + {1'b0, below_rgb[c*COLOR_W +: COLOR_W]};
        mix_rgb[c*COLOR_W +: COLOR_W] = COLOR_W'(blend_sum >> 1);
      end
    end
`endif
    pix_d = '0;
    hit_d = 1'b0;
    idx_d = '0;
    if (de_s1_q) begin
      if (win_vld) begin
        pix_d = mix_rgb;
        hit_d = 1'b1;
        idx_d = win_idx;
      end else begin
        pix_d = bg_color;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_s1_q  <= '0;
      rgb_s1_q  <= '0;
      de_s1_q   <= 1'b0;
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      x_s1_q    <= '0;
      y_s1_q    <= '0;
      vs_prev_q <= 1'b0;
      mask_q    <= '1;
      fcnt_q    <= '0;
      pix_q     <= '0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
      de_s2_q   <= 1'b0;
      hs_s2_q   <= 1'b0;
      vs_s2_q   <= 1'b0;
      x_s2_q    <= '0;
      y_s2_q    <= '0;
    end else begin
      req_s1_q  <= req;
      rgb_s1_q  <= rgb_in;
      de_s1_q   <= de_in;
      hs_s1_q   <= hs_in;
      vs_s1_q   <= vs_in;
      x_s1_q    <= x_pos;
      y_s1_q    <= y_pos;
      vs_prev_q <= vs_in;
      mask_q    <= mask_d;
      fcnt_q    <= fcnt_d;
      pix_q     <= pix_d;
      hit_q     <= hit_d;
      idx_q     <= idx_d;
      de_s2_q   <= de_s1_q;
      hs_s2_q   <= hs_s1_q;
      vs_s2_q   <= vs_s1_q;
      x_s2_q    <= x_s1_q;
      y_s2_q    <= y_s1_q;
    end
  end

  assign red       = pix_q[chan_lsb(CH_R, COLOR_W) +: COLOR_W];
  assign green     = pix_q[chan_lsb(CH_G, COLOR_W) +: COLOR_W];
  assign blue      = pix_q[chan_lsb(CH_B, COLOR_W) +: COLOR_W];
  assign hit       = hit_q;
  assign top_idx   = idx_q;
  assign de_out    = de_s2_q;
  assign hs_out    = hs_s2_q;
  assign vs_out    = vs_s2_q;
  assign x_out     = x_s2_q;
  assign y_out     = y_s2_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed scenarios plus randomized
// traffic against a frame/pixel-level reference model.
module tb_layer_compositor;

  localparam int NL = 4;
  localparam int CW = 8;
  localparam int PW = 3 * CW;
  localparam int FW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        x_pos, y_pos;
  logic              de_in, hs_in, vs_in;
  logic [NL-1:0]     req, layer_en_in;
  logic [NL*PW-1:0]  rgb_in;
  logic [PW-1:0]     bg_color;
`ifdef LAYER_BLEND_EN
  logic [NL-1:0]     blend_mask;
`endif
  logic [CW-1:0]     red, green, blue;
  logic              de_out, hs_out, vs_out, hit;
  logic [9:0]        x_out, y_out;
  logic [1:0]        top_idx;
  logic [FW-1:0]     frame_cnt;

  always #5 clk = ~clk;

  layer_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW), .IDX_W(2), .FCNT_W(FW)) dut (
    .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos),
    .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .req(req), .rgb_in(rgb_in), .layer_en_in(layer_en_in), .bg_color(bg_color),
`ifdef LAYER_BLEND_EN
    .blend_mask(blend_mask),
`endif
    .red(red), .green(green), .blue(blue),
    .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out),
    .x_out(x_out), .y_out(y_out), .top_idx(top_idx), .hit(hit), .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic [NL-1:0]    req;
    logic [NL*PW-1:0] rgb;
    logic             de, hs, vs;
    logic [9:0]       x, y;
  } pix_t;

  typedef struct {
    logic [PW-1:0] rgb;
    logic          hit;
    logic [1:0]    idx;
    logic          de, hs, vs;
    logic [9:0]    x, y;
  } res_t;

  pix_t          s1_m;
  res_t          out_m;
  logic [NL-1:0] mask_m;
  logic          vs_prev_m;
  int            fcnt_m;
  int            n_checks = 0;
  int            n_pass   = 0;

  function automatic logic [NL-1:0] cur_bm();
`ifdef LAYER_BLEND_EN
    return blend_mask;
`else
    return '0;
`endif
  endfunction

  // Reference rule: topmost enabled request wins; blending averages with the next one down.
  function automatic res_t compute(input pix_t p, input logic [NL-1:0] m,
                                   input logic [PW-1:0] bg, input logic [NL-1:0] bm);
    res_t          r;
    logic [NL-1:0] eff;
    logic [PW-1:0] cw, cb;
    int            w, b;
    eff = p.req & m;
    w = -1;
    b = -1;
    r.rgb = '0; r.hit = 1'b0; r.idx = '0;
    r.de = p.de; r.hs = p.hs; r.vs = p.vs; r.x = p.x; r.y = p.y;
    for (int i = NL - 1; i >= 0; i--) begin
      if (eff[i]) begin
        if (w < 0) w = i;
        else if (b < 0) b = i;
      end
    end
    if (p.de) begin
      if (w < 0) begin
        r.rgb = bg;
      end else begin
        cw = p.rgb[w*PW +: PW];
        r.rgb = cw;
        r.hit = 1'b1;
        r.idx = 2'(w);
        if (bm[w]) begin
          if (b < 0) cb = bg;
          else cb = p.rgb[b*PW +: PW];
          for (int c = 0; c < 3; c++)
            r.rgb[c*CW +: CW] = 8'((int'(cw[c*CW +: CW]) + int'(cb[c*CW +: CW])) / 2);
        end
      end
    end
    return r;
  endfunction

  // One clock: advance the model at the edge the DUT samples, then settle to the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      s1_m      = '{default: '0};
      out_m     = '{default: '0};
      mask_m    = '1;
      vs_prev_m = 1'b0;
      fcnt_m    = 0;
    end else begin
      out_m = compute(s1_m, mask_m, bg_color, cur_bm());
      if (vs_in && !vs_prev_m) begin
        mask_m = layer_en_in;
        fcnt_m = (fcnt_m + 1) % (1 << FW);
      end
      vs_prev_m = vs_in;
      s1_m.req = req; s1_m.rgb = rgb_in; s1_m.de = de_in; s1_m.hs = hs_in;
      s1_m.vs = vs_in; s1_m.x = x_pos; s1_m.y = y_pos;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; x_pos = '0; y_pos = '0; de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    req = '0; rgb_in = '0; layer_en_in = '1; bg_color = '0;
`ifdef LAYER_BLEND_EN
    blend_mask = '0;
`endif
    tick(); tick();
    n_checks++;
    if ({red, green, blue, hit, top_idx} !== 27'd0)
      $display("FAIL reset_pix got=%h/%b/%0d want=0/0/0", {red, green, blue}, hit, top_idx);
    else n_pass++;
    n_checks++;
    if ({de_out, hs_out, vs_out, x_out, y_out, frame_cnt} !== 27'd0)
      $display("FAIL reset_sync got=%b%b%b x=%0d y=%0d fc=%0d want all 0", de_out, hs_out, vs_out, x_out, y_out, frame_cnt);
    else n_pass++;
    $display("reset: rgb=%h hit=%b fc=%0d", {red, green, blue}, hit, frame_cnt);
    rst = 1'b0;
  endtask

  task automatic test_priority();
    rgb_in = {$urandom, $urandom, $urandom};
    rgb_in[0*PW +: PW] = 24'h112233;
    rgb_in[2*PW +: PW] = 24'hAABBCC;
    req = 4'b0101; de_in = 1'b1;
    tick(); tick();
    n_checks++;
    if ({red, green, blue} !== 24'hAABBCC || hit !== 1'b1 || top_idx !== 2'd2)
      $display("FAIL prio_0101 got=%h/%b/%0d want=aabbcc/1/2", {red, green, blue}, hit, top_idx);
    else n_pass++;
    $display("priority: req=0101 rgb=%h idx=%0d", {red, green, blue}, top_idx);
  endtask

  task automatic test_background();
    req = '0; bg_color = 24'h102030; de_in = 1'b1;
    tick(); tick();
    n_checks++;
    if ({red, green, blue} !== 24'h102030 || hit !== 1'b0)
      $display("FAIL bg_fill got=%h/%b want=102030/0", {red, green, blue}, hit);
    else n_pass++;
    $display("background: rgb=%h hit=%b", {red, green, blue}, hit);
    de_in = 1'b0; req = 4'b1111;
    tick(); tick();
    n_checks++;
    if ({red, green, blue} !== 24'h0 || hit !== 1'b0 || top_idx !== 2'd0)
      $display("FAIL blank_de0 got=%h/%b/%0d want=0/0/0", {red, green, blue}, hit, top_idx);
    else n_pass++;
    $display("blanking: rgb=%h hit=%b", {red, green, blue}, hit);
  endtask

  task automatic test_shadow_mask();
    int fc0;
    fc0 = fcnt_m;
    de_in = 1'b1; req = 4'b1000; rgb_in[3*PW +: PW] = 24'h445566;
    layer_en_in = 4'b0111; vs_in = 1'b0;
    tick(); tick();
    n_checks++;
    if ({red, green, blue} !== 24'h445566 || top_idx !== 2'd3 || hit !== 1'b1)
      $display("FAIL mask_midframe got=%h/%0d/%b want=445566/3/1", {red, green, blue}, top_idx, hit);
    else n_pass++;
    vs_in = 1'b1;
    tick();
    n_checks++;
    if (frame_cnt !== FW'(fc0 + 1))
      $display("FAIL fcnt_edge got=%0d want=%0d", frame_cnt, FW'(fc0 + 1));
    else n_pass++;
    tick();
    n_checks++;
    if ({red, green, blue} !== 24'h102030 || hit !== 1'b0)
      $display("FAIL mask_applied got=%h/%b want=102030/0", {red, green, blue}, hit);
    else n_pass++;
    tick(); tick(); tick();
    n_checks++;
    if (frame_cnt !== FW'(fc0 + 1))
      $display("FAIL fcnt_held_high got=%0d want=%0d", frame_cnt, FW'(fc0 + 1));
    else n_pass++;
    $display("shadow: after vs high 5 cycles fc=%0d rgb=%h", frame_cnt, {red, green, blue});
    vs_in = 1'b0; layer_en_in = 4'b1111;
    tick(); tick();
    n_checks++;
    if (hit !== 1'b0)
      $display("FAIL mask_no_early_update got hit=%b want=0", hit);
    else n_pass++;
    vs_in = 1'b1; tick(); vs_in = 1'b0; tick(); tick();
    n_checks++;
    if (top_idx !== 2'd3 || hit !== 1'b1 || frame_cnt !== FW'(fc0 + 2))
      $display("FAIL mask_restore got=%0d/%b fc=%0d want=3/1 fc=%0d", top_idx, hit, frame_cnt, FW'(fc0 + 2));
    else n_pass++;
    $display("shadow: restored idx=%0d fc=%0d", top_idx, frame_cnt);
  endtask

  task automatic test_alignment();
    logic [24:0] drv [14];
    logic [24:0] got;
    for (int k = 0; k < 14; k++) begin
      x_pos = 10'(632 + k); y_pos = 10'(100 + k / 8);
      hs_in = (k % 5 == 3); vs_in = (k == 6 || k == 7); de_in = (k < 8);
      drv[k] = {de_in, hs_in, vs_in, x_pos, y_pos};
      tick();
      if (k >= 1) begin
        got = {de_out, hs_out, vs_out, x_out, y_out};
        n_checks++;
        if (got !== drv[k-1])
          $display("FAIL align k=%0d got de/hs/vs=%b x=%0d y=%0d want=%b x=%0d y=%0d", k, got[24:22], got[19:10], got[9:0], drv[k-1][24:22], drv[k-1][19:10], drv[k-1][9:0]);
        else n_pass++;
        $display("align: k=%0d x_out=%0d y_out=%0d de/hs/vs=%b%b%b", k, x_out, y_out, de_out, hs_out, vs_out);
      end
    end
    vs_in = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 160; n++) begin
      req = NL'($urandom); rgb_in = {$urandom, $urandom, $urandom};
      layer_en_in = NL'($urandom); bg_color = PW'($urandom);
      de_in = ($urandom_range(0, 4) != 0); hs_in = 1'($urandom);
      if ($urandom_range(0, 5) == 0) vs_in = ~vs_in;
      x_pos = 10'($urandom); y_pos = 10'($urandom);
`ifdef LAYER_BLEND_EN
      blend_mask = NL'($urandom);
`endif
      tick();
      n_checks++;
      if ({red, green, blue} !== out_m.rgb || hit !== out_m.hit || top_idx !== out_m.idx)
        $display("FAIL rand_pix n=%0d got=%h/%b/%0d want=%h/%b/%0d", n, {red, green, blue}, hit, top_idx, out_m.rgb, out_m.hit, out_m.idx);
      else n_pass++;
      n_checks++;
      if ({de_out, hs_out, vs_out, x_out, y_out} !== {out_m.de, out_m.hs, out_m.vs, out_m.x, out_m.y})
        $display("FAIL rand_sync n=%0d got=%b%b%b x=%0d y=%0d want=%b%b%b x=%0d y=%0d", n, de_out, hs_out, vs_out, x_out, y_out, out_m.de, out_m.hs, out_m.vs, out_m.x, out_m.y);
      else n_pass++;
      n_checks++;
      if (frame_cnt !== FW'(fcnt_m))
        $display("FAIL rand_fcnt n=%0d got=%0d want=%0d", n, frame_cnt, FW'(fcnt_m));
      else n_pass++;
      $display("rand: n=%0d rgb=%h hit=%b idx=%0d fc=%0d", n, {red, green, blue}, hit, top_idx, frame_cnt);
    end
    vs_in = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    de_in = 1'b1; req = 4'b1111; layer_en_in = 4'b0001; bg_color = 24'h102030;
`ifdef LAYER_BLEND_EN
    blend_mask = '0;
`endif
    rgb_in[0*PW +: PW] = 24'h0A0B0C; rgb_in[3*PW +: PW] = 24'hD0E0F0;
    vs_in = 1'b0; tick(); vs_in = 1'b1; tick(); vs_in = 1'b0; tick();
    n_checks++;
    if (top_idx !== 2'd0 || {red, green, blue} !== 24'h0A0B0C)
      $display("FAIL mask_0001 got=%0d/%h want=0/0a0b0c", top_idx, {red, green, blue});
    else n_pass++;
    rst = 1'b1; tick();
    n_checks++;
    if ({red, green, blue, hit, top_idx, de_out, frame_cnt} !== 32'd0)
      $display("FAIL mid_reset got=%h/%b/%0d de=%b fc=%0d want all 0", {red, green, blue}, hit, top_idx, de_out, frame_cnt);
    else n_pass++;
    rst = 1'b0; tick();
    n_checks++;
    if ({red, green, blue, hit, de_out} !== 26'd0)
      $display("FAIL post_reset_flush got=%h/%b de=%b want=0/0/0", {red, green, blue}, hit, de_out);
    else n_pass++;
    tick();
    n_checks++;
    if (top_idx !== 2'd3 || hit !== 1'b1 || {red, green, blue} !== 24'hD0E0F0)
      $display("FAIL mask_reset_ones got=%0d/%b/%h want=3/1/d0e0f0", top_idx, hit, {red, green, blue});
    else n_pass++;
    $display("reset_mid: idx=%0d rgb=%h", top_idx, {red, green, blue});
  endtask

  task automatic test_frame_wrap();
    layer_en_in = '1;
    for (int p = 1; p <= 16; p++) begin
      vs_in = 1'b1; tick(); vs_in = 1'b0; tick();
      $display("wrap: pulse=%0d fc=%0d", p, frame_cnt);
      if (p == 15) begin
        n_checks++;
        if (frame_cnt !== 4'd15) $display("FAIL fcnt_15 got=%0d want=15", frame_cnt);
        else n_pass++;
      end
    end
    n_checks++;
    if (frame_cnt !== 4'd0) $display("FAIL fcnt_wrap got=%0d want=0", frame_cnt);
    else n_pass++;
  endtask

`ifdef LAYER_BLEND_EN
  task automatic test_blend();
    de_in = 1'b1; req = 4'b0011; blend_mask = 4'b0010; bg_color = 24'h102030;
    rgb_in[1*PW +: PW] = 24'hFF0000; rgb_in[0*PW +: PW] = 24'h0000FF;
    tick(); tick();
    n_checks++;
    if ({red, green, blue} !== 24'h7F007F || top_idx !== 2'd1 || hit !== 1'b1)
      $display("FAIL blend_layers got=%h/%0d/%b want=7f007f/1/1", {red, green, blue}, top_idx, hit);
    else n_pass++;
    req = 4'b0010;
    tick(); tick();
    n_checks++;
    if ({red, green, blue} !== 24'h871018 || top_idx !== 2'd1)
      $display("FAIL blend_bg got=%h/%0d want=871018/1", {red, green, blue}, top_idx);
    else n_pass++;
    $display("blend: rgb=%h idx=%0d", {red, green, blue}, top_idx);
  endtask
`endif

  initial begin
    test_reset();
    test_priority();
    test_background();
    test_shadow_mask();
    test_alignment();
    test_random();
    test_reset_mid();
    test_frame_wrap();
`ifdef LAYER_BLEND_EN
    test_blend();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
